// File: rtl/fetch_unit_if.sv
// Fetch-unit handshakes: imem request/response channels, redirect input and decoder output.
// master = fetch unit side, slave = memory/decoder/branch side.
interface fetch_unit_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [DATA_WIDTH-1:0] imem_req_addr;
   logic                  imem_rsp_valid;
   logic [DATA_WIDTH-1:0] imem_rsp_data;
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instruction;
   logic [DATA_WIDTH-1:0] instr_pc;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, instruction FIFO, redirect flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  fetch_count,
   output logic [31:0]  stall_count
`endif
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         out_q, out_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] disc_q, disc_d;
   logic [AW-1:0]         aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
   logic [AW-1:0]         iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;

   logic [DATA_WIDTH-1:0] aq_mem  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] iq_data [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] iq_pc   [FIFO_DEPTH];

   logic        redir;
   logic        pop;
   logic        req_valid;
   logic        accept;
   logic        rsp_drop;
   logic        rsp_take;
   logic        head_valid;
   logic [CW:0] credit;

   // Credits cover both in-flight requests and buffered words, so a push never hits a full FIFO.
   always_comb begin
      redir      = bus.redirect_valid;
      head_valid = (cnt_q != '0);
      pop        = head_valid && bus.instr_ready;
      credit     = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
      req_valid  = !rst && !redir && (credit < DEPTH_C);
      accept     = req_valid && bus.imem_req_ready;
      rsp_drop   = bus.imem_rsp_valid && (disc_q != '0);
      rsp_take   = bus.imem_rsp_valid && (disc_q == '0) && (out_q != '0);
   end

   always_comb begin
      pc_d    = pc_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      disc_d  = disc_q;
      aq_wr_d = aq_wr_q;
      aq_rd_d = aq_rd_q;
      iq_wr_d = iq_wr_q;
      iq_rd_d = iq_rd_q;
      if (redir) begin
         // Everything still in flight becomes a response to discard.
         pc_d    = bus.redirect_pc & ~DATA_WIDTH'(3);
         out_d   = '0;
         cnt_d   = '0;
         aq_wr_d = '0;
         aq_rd_d = '0;
         iq_wr_d = '0;
         iq_rd_d = '0;
         disc_d  = disc_q + DATA_WIDTH'(out_q) - DATA_WIDTH'(rsp_drop || rsp_take);
      end else begin
         if (accept) begin
            pc_d    = pc_q + DATA_WIDTH'(4);
            aq_wr_d = aq_wr_q + AW'(1);
         end
         if (rsp_take) begin
            aq_rd_d = aq_rd_q + AW'(1);
            iq_wr_d = iq_wr_q + AW'(1);
         end
         if (pop) begin
            iq_rd_d = iq_rd_q + AW'(1);
         end
         out_d  = out_q + CW'(accept) - CW'(rsp_take);
         cnt_d  = cnt_q + CW'(rsp_take) - CW'(pop);
         disc_d = disc_q - DATA_WIDTH'(rsp_drop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         out_q   <= '0;
         cnt_q   <= '0;
         disc_q  <= '0;
         aq_wr_q <= '0;
         aq_rd_q <= '0;
         iq_wr_q <= '0;
         iq_rd_q <= '0;
      end else begin
         pc_q    <= pc_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         disc_q  <= disc_d;
         aq_wr_q <= aq_wr_d;
         aq_rd_q <= aq_rd_d;
         iq_wr_q <= iq_wr_d;
         iq_rd_q <= iq_rd_d;
      end
   end

   // Storage arrays carry data only; validity is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (accept) begin
         aq_mem[aq_wr_q] <= pc_q;
      end
      if (rsp_take && !redir) begin
         iq_data[iq_wr_q] <= bus.imem_rsp_data;
         iq_pc[iq_wr_q]   <= aq_mem[aq_rd_q];
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.instr_valid    = head_valid;
   assign bus.instruction    = head_valid ? iq_data[iq_rd_q] : '0;
   assign bus.instr_pc       = head_valid ? iq_pc[iq_rd_q]   : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // A pop coinciding with a redirect is discarded, so it is not counted as a fetch.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q + 32'(pop && !redir);
      stall_cnt_d = stall_cnt_q + 32'(bus.instr_ready && !head_valid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of core_l1.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small FIFO and presents instruction/PC pairs to the decoder over a valid/ready handshake.
- Handles control-flow redirects by flushing buffered words and discarding in-flight responses.

Parameters:
DATA_WIDTH, 32, instruction/address width
FIFO_DEPTH, 4, instruction buffer entries; also the cap on (outstanding requests + buffered words); power of 2, >= 2
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  DATA_WIDTH  word-aligned fetch address
imem_rsp_valid  input  1  response word valid; in order, at most one per cycle
imem_rsp_data  input  DATA_WIDTH  response instruction word
redirect_valid  input  1  branch/jump taken, one-cycle pulse
redirect_pc  input  DATA_WIDTH  new PC; bits [1:0] ignored (forced 00)
instr_valid  output  1  instruction/instr_pc valid to decoder
instr_ready  input  1  decoder consumes head entry
instruction  output  DATA_WIDTH  head instruction word
instr_pc  output  DATA_WIDTH  address of head instruction

Behaviour:
Reset (async assert):
- pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
- imem_req_valid=0; instr_valid=0; instruction=0; instr_pc=0.

Request issue:
- imem_req_valid=1 when (outstanding + fifo_count - pop) < FIFO_DEPTH and redirect_valid=0. pop = instr_valid & instr_ready.
- imem_req_addr=pc.
- On accept (valid & ready): pc<=pc+4, outstanding+1, and the address is pushed to an internal address queue.
- Once raised, imem_req_valid and imem_req_addr stay stable until accepted. The only exception is a redirect, which withdraws the request.
- pc wraps modulo 2^DATA_WIDTH.

Response:
- Earliest response is the cycle after accept.
- If discard>0, the response is dropped and discard decrements.
- Otherwise {imem_rsp_data, head of address queue} is pushed to the FIFO and outstanding decrements.
- The credit rule guarantees a push never finds the FIFO full. Same-cycle push and pop is legal at any fill level.
- A response with outstanding=0 and discard=0 is ignored.

Output:
- instr_valid = FIFO non-empty; instruction and instr_pc come from the head.
- Head is held stable while instr_valid & !instr_ready.
- Latency: a response in cycle N is visible on instr_valid at N+1.
- Steady-state throughput is 1 instruction/cycle with 1-cycle memory.

Redirect (highest priority):
- In the redirect cycle: FIFO flushed, address queue cleared, pc<=redirect_pc & ~3.
- discard <= discard + outstanding + (response this cycle that would otherwise count ? -1 : 0). outstanding<=0.
- No request is issued in the redirect cycle. A pop in the same cycle is ignored.
- instr_valid=0 from the next cycle until the first post-redirect word arrives.
- Back-to-back redirects: the last one wins; discard keeps accumulating.

Reset mid-operation: all state returns to reset values immediately. Memory responses arriving after rst deasserts with outstanding=0 are ignored.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on each FIFO pop.
  - stall_count increments each cycle with instr_ready=1 and instr_valid=0.
  - Both counters wrap.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0, memory ready=1, 1-cycle latency returning 00252283, 00339603, ... -> addresses 0, 4, 8, ... requested; instr_valid from cycle 3; pairs (00252283, 0), (00339603, 4) in order at 1/cycle.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 requests accepted; then imem_req_valid=0; head stable. instr_ready=1 -> 4 pops, then fetching resumes at pc=0x10.
- imem_req_ready low for 3 cycles with valid high -> imem_req_addr held at 0x8, no PC advance.
- Redirect to 0x103 with 2 requests outstanding (3-cycle memory) -> 2 responses dropped; next request addr 0x100; first instr_pc=0x100.
- Redirect in the same cycle as a response and a pop -> response dropped, pop ignored, instr_valid=0 next cycle.
- rst asserted mid-stream with 3 entries buffered -> instr_valid and imem_req_valid fall without waiting for clk; after release, first address is RESET_PC.
